mul_share_arbiter: RTL



---
 rtl/mul_share_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between NUM_REQ
// requesters; one operation in flight, tagged result returned to its owner.
module mul_share_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MUL_DATA_SIZE = 16,
  parameter int DATA_SIZE     = 32,
  parameter int ID_SIZE       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*MUL_DATA_SIZE-1:0]   req_a,
  input  logic [NUM_REQ*MUL_DATA_SIZE-1:0]   req_b,
  input  logic [NUM_REQ*ID_SIZE-1:0]         req_id,
  output logic [MUL_DATA_SIZE-1:0]           mul_a_in,
  output logic [MUL_DATA_SIZE-1:0]           mul_b_in,
  output logic [ID_SIZE-1:0]                 mul_id,
  output logic                               mul_valid_data,
  input  logic                               mul_ready_data,
  output logic                               mul_ready_f_res,
  input  logic                               mul_valid_res,
  input  logic [DATA_SIZE+ID_SIZE:0]         mul_result,
  output logic                               mul_written,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  input  logic [NUM_REQ-1:0]                 rsp_ready,
  output logic [DATA_SIZE+ID_SIZE:0]         rsp_data
);

  localparam int GRANT_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, WRITE, RESP
  } state_e;

  state_e state_q, state_d;

  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [GRANT_W-1:0] owner_q, owner_d;
  logic [GRANT_W-1:0] win, cand;
  logic               found, accept;

  logic [MUL_DATA_SIZE-1:0]    a_q, a_d;
  logic [MUL_DATA_SIZE-1:0]    b_q, b_d;
  logic [ID_SIZE-1:0]          id_q, id_d;
  logic [DATA_SIZE+ID_SIZE:0]  res_q, res_d;

  // First valid requester at or after ptr, wrapping around
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = GRANT_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign accept = (state_q == IDLE) && !rst
                && mul_ready_data && found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (mul_valid_res) state_d = WRITE;
      WRITE: state_d = RESP;
      RESP:  if (rsp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands stay latched after issue; the multiplier samples them late
  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    res_d   = res_q;
    if (accept) begin
      ptr_d   = (win == GRANT_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      owner_d = win;
      a_d     = req_a[int'(win)*MUL_DATA_SIZE +: MUL_DATA_SIZE];
      b_d     = req_b[int'(win)*MUL_DATA_SIZE +: MUL_DATA_SIZE];
      id_d    = req_id[int'(win)*ID_SIZE +: ID_SIZE];
    end
    if (state_q == WAIT && mul_valid_res)
      res_d = mul_result;
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (accept)
      req_ready[win] = 1'b1;
    if (state_q == RESP)
      rsp_valid[owner_q] = 1'b1;
    mul_valid_data  = (state_q == ISSUE);
    mul_written     = (state_q == WRITE);
    mul_ready_f_res = (state_q == IDLE) || (state_q == ISSUE)
                   || (state_q == WAIT);
  end

  assign mul_a_in = a_q;
  assign mul_b_in = b_q;
  assign mul_id   = id_q;
  assign rsp_data = res_q;

endmodule
